// File: rtl/game2048_pkg.sv
// Shared codes, command directions, FSM states and board index helpers for the
// 4x4 board: slot s lives in bits [4s+3:4s], row r holds slots 4r..4r+3.
package game2048_pkg;

  localparam logic [3:0] EMPTY        = 4'd0;
  localparam logic [3:0] WIN_CODE     = 4'd11;
  localparam int         SAT_CODE_DEF = 15;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MERGE = 3'd2,
    ST_SPAWN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Board slot for position pos of line l; pos 0 is the edge tiles slide toward.
  function automatic logic [3:0] slot_idx(input logic [1:0] dir,
                                          input logic [1:0] l,
                                          input logic [1:0] pos);
    case (dir)
      DIR_UP:   return {pos, l};
      DIR_DOWN: return {2'd3 - pos, l};
      DIR_LEFT: return {l, pos};
      default:  return {l, 2'd3 - pos};
    endcase
  endfunction

endpackage

// File: rtl/board_update_if.sv
// Command/board bus between the key decoder (master) and board_update (slave).
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only while idle, and done pulses one cycle when slots,
// moved and score_delta carry the result of that command.
interface board_update_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dir;
  logic        cmd_new;
  logic [63:0] slots;
  logic        done;
  logic        moved;
  logic [19:0] score_delta;

  modport master (
    output cmd_valid, cmd_dir, cmd_new,
    input  cmd_ready, slots, done, moved, score_delta
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_new,
    output cmd_ready, slots, done, moved, score_delta
  );
endinterface

// File: rtl/board_update_line_merge.sv
// Combinational slide/merge of one 4-tile line toward index 0, with the
// score earned by its merges; each tile merges at most once.
module line_merge
  import game2048_pkg::*;
#(
  parameter int SAT_CODE = SAT_CODE_DEF
) (
  input  logic [15:0] line_i,
  output logic [15:0] line_o,
  output logic        moved_o,
  output logic [16:0] score_o
);

  logic [3:0] cmp [5];
  logic [3:0] res [4];
  logic [2:0] cnt;
  logic [2:0] wr;
  logic       skip;
  logic [4:0] code;

  always_comb begin
    for (int i = 0; i < 5; i++) cmp[i] = EMPTY;
    cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (line_i[4*i +: 4] != EMPTY) begin
        cmp[cnt] = line_i[4*i +: 4];
        cnt      = cnt + 3'd1;
      end
    end

    // cmp[4] stays empty so the last tile never finds a partner.
    for (int i = 0; i < 4; i++) res[i] = EMPTY;
    score_o = '0;
    wr      = '0;
    skip    = 1'b0;
    code    = '0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i] != EMPTY) begin
        if (cmp[i] == cmp[i+1]) begin
          code = {1'b0, cmp[i]} + 5'd1;
          if (code > 5'(SAT_CODE)) code = 5'(SAT_CODE);
          score_o = score_o + (17'd1 << code);
          skip    = 1'b1;
        end else begin
          code = {1'b0, cmp[i]};
        end
        res[wr[1:0]] = code[3:0];
        wr           = wr + 3'd1;
      end
    end

    line_o  = {res[3], res[2], res[1], res[0]};
    moved_o = (line_o != line_i);
  end

endmodule

// File: rtl/board_update.sv
// Executes one move or new-game command on the committed 4x4 board: four
// time-shared line merges, then an LFSR-driven tile spawn, then a commit.
module board_update
  import game2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          FOUR_BITS = 3,
  parameter int          SAT_CODE  = SAT_CODE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  board_update_if.slave        bus,
  output state_e               dbg_state_o
);

  state_e      state_q;
  logic [1:0]  line_q;
  logic [1:0]  dir_q;
  logic [3:0]  ptr_q;
  logic [3:0]  cnt_q;
  logic        second_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [63:0] wb_q;
  logic        mv_q;
  logic [19:0] sc_q;
  logic [63:0] slots_q;
  logic        done_q;
  logic        moved_q;
  logic [19:0] score_q;

  logic [15:0] line_in;
  logic [15:0] line_out;
  logic        line_moved;
  logic [16:0] line_score;
  logic [63:0] wb_merged;
  logic [63:0] wb_spawn;
  logic [3:0]  spawn_code;
  logic        slot_empty;
  logic        moved_final;

  line_merge #(.SAT_CODE(SAT_CODE)) u_line_merge (
    .line_i  (line_in),
    .line_o  (line_out),
    .moved_o (line_moved),
    .score_o (line_score)
  );

  always_comb begin
    line_in = '0;
    for (int p = 0; p < 4; p++)
      line_in[4*p +: 4] = wb_q[{slot_idx(dir_q, line_q, 2'(p)), 2'b00} +: 4];
  end

  always_comb begin
    wb_merged = wb_q;
    for (int p = 0; p < 4; p++)
      wb_merged[{slot_idx(dir_q, line_q, 2'(p)), 2'b00} +: 4] = line_out[4*p +: 4];
  end

  always_comb begin
    spawn_code = (lfsr_q[FOUR_BITS-1:0] == '0) ? 4'd2 : 4'd1;
    slot_empty = (wb_q[{ptr_q, 2'b00} +: 4] == EMPTY);
    wb_spawn   = wb_q;
    wb_spawn[{ptr_q, 2'b00} +: 4] = spawn_code;
  end

  // Lines are disjoint and wb starts as slots, so any line change means the board changed.
  assign moved_final = mv_q | line_moved;
  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      dir_q    <= DIR_UP;
      ptr_q    <= '0;
      cnt_q    <= '0;
      second_q <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      wb_q     <= '0;
      mv_q     <= 1'b0;
      sc_q     <= '0;
      slots_q  <= '0;
      done_q   <= 1'b0;
      moved_q  <= 1'b0;
      score_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            wb_q    <= slots_q;
            line_q  <= '0;
            dir_q   <= bus.cmd_dir;
            mv_q    <= 1'b0;
            sc_q    <= '0;
            state_q <= bus.cmd_new ? ST_CLEAR : ST_MERGE;
          end
        end
        ST_CLEAR: begin
          wb_q     <= '0;
          mv_q     <= 1'b1;
          sc_q     <= '0;
          ptr_q    <= lfsr_q[3:0];
          cnt_q    <= '0;
          second_q <= 1'b1;
          state_q  <= ST_SPAWN;
        end
        ST_MERGE: begin
          wb_q   <= wb_merged;
          sc_q   <= sc_q + 20'(line_score);
          mv_q   <= moved_final;
          line_q <= line_q + 2'd1;
          if (line_q == 2'd3) begin
            if (moved_final) begin
              ptr_q    <= lfsr_q[3:0];
              cnt_q    <= '0;
              second_q <= 1'b0;
              state_q  <= ST_SPAWN;
            end else begin
              slots_q <= wb_merged;
              done_q  <= 1'b1;
              moved_q <= 1'b0;
              score_q <= sc_q + 20'(line_score);
              state_q <= ST_DONE;
            end
          end
        end
        ST_SPAWN: begin
          cnt_q <= cnt_q + 4'd1;
          if (slot_empty) wb_q  <= wb_spawn;
          else            ptr_q <= ptr_q + 4'd1;
          // A pass ends on the first empty slot or after 16 probes.
          if (slot_empty || cnt_q == 4'd15) begin
            if (second_q) begin
              second_q <= 1'b0;
              ptr_q    <= lfsr_q[3:0];
              cnt_q    <= '0;
            end else begin
              slots_q <= slot_empty ? wb_spawn : wb_q;
              done_q  <= 1'b1;
              moved_q <= mv_q;
              score_q <= sc_q;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.slots       = slots_q;
  assign bus.done        = done_q;
  assign bus.moved       = moved_q;
  assign bus.score_delta = score_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_board_update.sv
// Bench for board_update: directed board scenarios plus random boards checked
// against a queue-based slide/merge reference model.
module tb_board_update;
  import game2048_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  state_e      dbg_state;
  board_update_if bus();

  board_update dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] preload_val;
  logic [63:0] obs_slots;
  logic        obs_moved;
  logic [19:0] obs_score;
  int          obs_lat;

  // ---------------- reference model ----------------
  function automatic int sidx(input int dir, input int l, input int i);
    case (dir)
      0:       return l + 4*i;
      1:       return l + 12 - 4*i;
      2:       return 4*l + i;
      default: return 4*l + 3 - i;
    endcase
  endfunction

  function automatic void model_move(input logic [63:0] b, input int dir,
                                     output logic [63:0] nb, output int score);
    int q[$];
    int outl[$];
    int v;
    nb    = b;
    score = 0;
    for (int l = 0; l < 4; l++) begin
      q.delete();
      outl.delete();
      for (int i = 0; i < 4; i++) begin
        v = int'(b[4*sidx(dir, l, i) +: 4]);
        if (v != 0) q.push_back(v);
      end
      while (q.size() > 0) begin
        v = q.pop_front();
        if (q.size() > 0 && q[0] == v) begin
          void'(q.pop_front());
          v = (v + 1 > 15) ? 15 : v + 1;
          score += (1 << v);
        end
        outl.push_back(v);
      end
      for (int i = 0; i < 4; i++)
        nb[4*sidx(dir, l, i) +: 4] = (i < outl.size()) ? 4'(outl[i]) : 4'd0;
    end
  endfunction

  // Exactly one slot differs, it was empty, and it now holds a 2 or a 4.
  function automatic bit spawn_ok(input logic [63:0] e, input logic [63:0] g);
    int diffs = 0;
    bit good  = 1'b1;
    for (int s = 0; s < 16; s++) begin
      if (e[4*s +: 4] != g[4*s +: 4]) begin
        diffs++;
        if (e[4*s +: 4] != 4'd0 || !(g[4*s +: 4] inside {4'd1, 4'd2})) good = 1'b0;
      end
    end
    return good && (diffs == 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_new   = 1'b0;
    bus.cmd_dir   = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_board();
    @(negedge clk);
    force dut.slots_q = preload_val;
    @(posedge clk);
    #1;
    release dut.slots_q;
  endtask

  task automatic run_cmd(input logic [1:0] dir, input logic is_new);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_new   = is_new;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_new   = 1'b0;
    obs_lat = 1;
    while (bus.done !== 1'b1 && obs_lat < 40) begin
      @(negedge clk);
      obs_lat++;
    end
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_timeout: done=%b after %0d cycles, required 1", bus.done, obs_lat);
    end
    obs_slots = bus.slots;
    obs_moved = bus.moved;
    obs_score = bus.score_delta;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks += 5;
    if (bus.slots !== 64'd0) begin n_fail++; $display("FAIL reset_slots: got %h required 0", bus.slots); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", bus.done); end
    if (bus.moved !== 1'b0) begin n_fail++; $display("FAIL reset_moved: got %b required 0", bus.moved); end
    if (bus.score_delta !== 20'd0) begin n_fail++; $display("FAIL reset_score: got %0d required 0", bus.score_delta); end
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.cmd_ready); end
  endtask

  task automatic test_merge_rows();
    logic [63:0] b [3];
    logic [1:0]  d [3];
    logic [63:0] e [3];
    int          s [3];
    b[0] = 64'h2211;                    d[0] = DIR_LEFT; e[0] = 64'h32; s[0] = 12;
    b[1] = 64'h1111;                    d[1] = DIR_LEFT; e[1] = 64'h22; s[1] = 8;
    b[2] = (64'd1 << 16) | (64'd1 << 48); d[2] = DIR_UP; e[2] = 64'h2;  s[2] = 4;
    for (int k = 0; k < 3; k++) begin
      preload_val = b[k];
      load_board();
      run_cmd(d[k], 1'b0);
      n_checks += 3;
      if (spawn_ok(e[k], obs_slots) !== 1'b1) begin n_fail++; $display("FAIL merge_board_%0d: got %h required %h plus one new tile", k, obs_slots, e[k]); end
      if (obs_moved !== 1'b1) begin n_fail++; $display("FAIL merge_moved_%0d: got %b required 1", k, obs_moved); end
      if (obs_score !== 20'(s[k])) begin n_fail++; $display("FAIL merge_score_%0d: got %0d required %0d", k, obs_score, s[k]); end
    end
  endtask

  task automatic test_no_move();
    logic [63:0] b [3];
    logic [1:0]  d [3];
    b[0] = 64'h2121_2121_2121_2121; d[0] = DIR_RIGHT;
    b[1] = 64'h3000;                d[1] = DIR_RIGHT;
    b[2] = 64'(WIN_CODE);           d[2] = DIR_LEFT;
    for (int k = 0; k < 3; k++) begin
      preload_val = b[k];
      load_board();
      run_cmd(d[k], 1'b0);
      n_checks += 4;
      if (obs_lat !== 5) begin n_fail++; $display("FAIL nomove_latency_%0d: got %0d required 5", k, obs_lat); end
      if (obs_moved !== 1'b0) begin n_fail++; $display("FAIL nomove_moved_%0d: got %b required 0", k, obs_moved); end
      if (obs_slots !== b[k]) begin n_fail++; $display("FAIL nomove_board_%0d: got %h required %h", k, obs_slots, b[k]); end
      if (obs_score !== 20'd0) begin n_fail++; $display("FAIL nomove_score_%0d: got %0d required 0", k, obs_score); end
    end
  endtask

  task automatic test_saturation();
    preload_val = 64'hFF;
    load_board();
    run_cmd(DIR_LEFT, 1'b0);
    n_checks += 3;
    if (spawn_ok(64'hF, obs_slots) !== 1'b1) begin n_fail++; $display("FAIL sat_board: got %h required 000f plus one new tile", obs_slots); end
    if (obs_score !== 20'd32768) begin n_fail++; $display("FAIL sat_score: got %0d required 32768", obs_score); end
    if (obs_moved !== 1'b1) begin n_fail++; $display("FAIL sat_moved: got %b required 1", obs_moved); end
  endtask

  task automatic test_new_game();
    int nz;
    int bad;
    for (int k = 0; k < 3; k++) begin
      preload_val = {$urandom, $urandom};
      load_board();
      run_cmd(2'($urandom_range(0, 3)), 1'b1);
      nz  = 0;
      bad = 0;
      for (int s = 0; s < 16; s++) begin
        if (obs_slots[4*s +: 4] != 4'd0) begin
          nz++;
          if (!(obs_slots[4*s +: 4] inside {4'd1, 4'd2})) bad++;
        end
      end
      n_checks += 4;
      if (nz !== 2) begin n_fail++; $display("FAIL new_tile_count_%0d: got %0d required 2 (%h)", k, nz, obs_slots); end
      if (bad !== 0) begin n_fail++; $display("FAIL new_tile_code_%0d: got %0d bad tiles required 0 (%h)", k, bad, obs_slots); end
      if (obs_moved !== 1'b1) begin n_fail++; $display("FAIL new_moved_%0d: got %b required 1", k, obs_moved); end
      if (obs_score !== 20'd0) begin n_fail++; $display("FAIL new_score_%0d: got %0d required 0", k, obs_score); end
    end
  endtask

  task automatic test_busy_ignored();
    int          cyc;
    bit          ready_seen;
    bit          done_seen;
    logic [63:0] res;
    preload_val = 64'h2211;
    load_board();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = DIR_LEFT;
    bus.cmd_new   = 1'b0;
    @(posedge clk);
    cyc        = 0;
    ready_seen = 1'b0;
    done_seen  = 1'b0;
    while (!done_seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.cmd_ready !== 1'b0) ready_seen = 1'b1;
      if (bus.done === 1'b1) begin
        done_seen     = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_new   = 1'b0;
      end else begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_new   = 1'b1;
        bus.cmd_dir   = 2'($urandom_range(0, 3));
      end
    end
    res = bus.slots;
    n_checks += 4;
    if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got ready=1 while busy, required 0"); end
    if (done_seen !== 1'b1) begin n_fail++; $display("FAIL busy_done: got no done in %0d cycles, required done", cyc); end
    if (spawn_ok(64'h32, res) !== 1'b1) begin n_fail++; $display("FAIL busy_board: got %h required 0032 plus one new tile", res); end
    if (bus.score_delta !== 20'd12) begin n_fail++; $display("FAIL busy_score: got %0d required 12", bus.score_delta); end
    @(negedge clk);
    n_checks += 3;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b required 0", bus.done); end
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL busy_after_ready: got %b required 1", bus.cmd_ready); end
    if (bus.slots !== res) begin n_fail++; $display("FAIL busy_after_board: got %h required %h", bus.slots, res); end
  endtask

  task automatic test_reset_mid();
    preload_val = 64'h2211;
    load_board();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = DIR_LEFT;
    bus.cmd_new   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (bus.slots !== 64'd0) begin n_fail++; $display("FAIL midrst_slots: got %h required 0", bus.slots); end
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", bus.cmd_ready); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b required 0", bus.done); end
    rst = 1'b0;
  endtask

  task automatic test_wrap_spawn();
    logic [63:0] e;
    preload_val = 64'h5454_5454_5454_3201;
    e           = 64'h5454_5454_5454_3210;
    load_board();
    run_cmd(DIR_RIGHT, 1'b0);
    n_checks += 3;
    if (spawn_ok(e, obs_slots) !== 1'b1 || obs_slots[3:0] == 4'd0) begin
      n_fail++; $display("FAIL wrap_board: got %h required %h with slot0 in {1,2}", obs_slots, e);
    end
    if (obs_moved !== 1'b1) begin n_fail++; $display("FAIL wrap_moved: got %b required 1", obs_moved); end
    if (obs_score !== 20'd0) begin n_fail++; $display("FAIL wrap_score: got %0d required 0", obs_score); end
  endtask

  task automatic test_random_moves();
    logic [63:0] b;
    logic [63:0] e;
    logic [63:0] exp_board;
    int          sc;
    int          r;
    int          dir;
    for (int k = 0; k < 30; k++) begin
      b = '0;
      for (int s = 0; s < 16; s++) begin
        r = $urandom_range(0, 9);
        b[4*s +: 4] = (r < 4) ? 4'd0 : 4'(r - 3);
      end
      if (k % 10 == 9) b[3:0] = 4'd15;
      dir = $urandom_range(0, 3);
      model_move(b, dir, e, sc);
      exp_q.push_back(e);
      preload_val = b;
      load_board();
      run_cmd(2'(dir), 1'b0);
      exp_board = exp_q.pop_front();
      n_checks += 3;
      if (obs_moved !== (exp_board != b)) begin n_fail++; $display("FAIL rand_moved_%0d: got %b required %b", k, obs_moved, exp_board != b); end
      if (obs_score !== 20'(sc)) begin n_fail++; $display("FAIL rand_score_%0d: got %0d required %0d", k, obs_score, sc); end
      if (exp_board != b) begin
        if (spawn_ok(exp_board, obs_slots) !== 1'b1) begin n_fail++; $display("FAIL rand_board_%0d: got %h required %h plus one new tile", k, obs_slots, exp_board); end
      end else begin
        if (obs_slots !== b) begin n_fail++; $display("FAIL rand_board_%0d: got %h required %h", k, obs_slots, b); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_new   = 1'b0;
    bus.cmd_dir   = 2'd0;
    preload_val   = '0;
    test_reset();
    test_merge_rows();
    test_no_move();
    test_saturation();
    test_new_game();
    test_busy_ignored();
    test_reset_mid();
    test_wrap_spawn();
    test_random_moves();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
